// File: rtl/sw_pkg.sv
// Shared types and field widths for the stopwatch core and its bus interface.
package sw_pkg;

    localparam int unsigned SEC_W   = 6;
    localparam int unsigned MIN_W   = 6;
    localparam int unsigned HOUR_W  = 4;
    localparam int unsigned SEC_MAX = 59;
    localparam int unsigned MIN_MAX = 59;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } sw_state_e;

    typedef struct packed {
        logic [HOUR_W-1:0] hour;
        logic [MIN_W-1:0]  min;
        logic [SEC_W-1:0]  sec;
    } sw_time_t;

endpackage

// File: rtl/stop_watch_lap_if.sv
// Command/preset inputs and display/status outputs of the stopwatch core.
interface stop_watch_lap_if;
    import sw_pkg::*;

    logic              start;
    logic              stop;
    logic              clear;
    logic              lap;
    logic              load;
    logic              mode_down;
    logic [HOUR_W-1:0] load_hour;
    logic [MIN_W-1:0]  load_min;
    logic [SEC_W-1:0]  load_sec;

    logic [HOUR_W-1:0] hour;
    logic [MIN_W-1:0]  min;
    logic [SEC_W-1:0]  sec;
    logic              running;
    logic              lap_hold;
    logic              done;
    logic              rollover;

    modport master (
        output start, stop, clear, lap, load, mode_down, load_hour, load_min, load_sec,
        input  hour, min, sec, running, lap_hold, done, rollover
    );

    modport slave (
        input  start, stop, clear, lap, load, mode_down, load_hour, load_min, load_sec,
        output hour, min, sec, running, lap_hold, done, rollover
    );

endinterface

// File: rtl/sw_tick_prescaler.sv
// Divides clk down to a one-second tick; holds its phase while disabled.
module sw_tick_prescaler #(
    parameter int unsigned TICK_DIV = 1,
    parameter int unsigned DIV_W    = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam logic [DIV_W-1:0] CNT_LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = enable && !clear && (cnt_q == CNT_LAST);

endmodule

// File: rtl/stop_watch_lap.sv
// Stopwatch core: run/pause/done FSM, h:m:s up/down counter chain and lap-hold display.
module stop_watch_lap
    import sw_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1,
    parameter int unsigned HOUR_MOD = 12,
    parameter int unsigned DIV_W    = 1
) (
    input  logic             clk,
    input  logic             reset,
    stop_watch_lap_if.slave  sw
);

    localparam logic [SEC_W-1:0]  SEC_LAST  = SEC_W'(SEC_MAX);
    localparam logic [MIN_W-1:0]  MIN_LAST  = MIN_W'(MIN_MAX);
    localparam logic [HOUR_W-1:0] HOUR_LAST = HOUR_W'(HOUR_MOD - 1);

    sw_state_e state_q, state_d;
    sw_time_t  cnt_q, cnt_d;
    sw_time_t  lap_q, lap_d;
    sw_time_t  disp_q, disp_d;
    logic      mode_q, mode_d;
    logic      lap_hold_q, lap_hold_d;
    logic      running_q, running_d;
    logic      done_q, done_d;
    logic      rollover_q, rollover_d;

    logic      tick_c;
    logic      presc_en_c;
    logic      presc_clr_c;
    logic      load_ok_c;
    logic      start_ok_c;
    logic      lap_ok_c;
    sw_time_t  load_time_c;

    function automatic sw_time_t time_inc(input sw_time_t t);
        sw_time_t r;
        r = t;
        if (t.sec != SEC_LAST) begin
            r.sec = t.sec + SEC_W'(1);
        end else begin
            r.sec = '0;
            if (t.min != MIN_LAST) begin
                r.min = t.min + MIN_W'(1);
            end else begin
                r.min  = '0;
                r.hour = (t.hour == HOUR_LAST) ? '0 : t.hour + HOUR_W'(1);
            end
        end
        return r;
    endfunction

    function automatic sw_time_t time_dec(input sw_time_t t);
        sw_time_t r;
        r = t;
        if (t.sec != '0) begin
            r.sec = t.sec - SEC_W'(1);
        end else begin
            r.sec = SEC_LAST;
            if (t.min != '0) begin
                r.min = t.min - MIN_W'(1);
            end else begin
                r.min  = MIN_LAST;
                r.hour = (t.hour == '0) ? HOUR_LAST : t.hour - HOUR_W'(1);
            end
        end
        return r;
    endfunction

    // Command qualification; only the highest-priority applicable command acts.
    assign load_ok_c   = sw.load && (state_q != RUN);
    assign start_ok_c  = sw.start && ((state_q == IDLE) || (state_q == PAUSE))
                         && !(sw.mode_down && (cnt_q == '0));
    assign lap_ok_c    = sw.lap && ((state_q == RUN) || ((state_q == PAUSE) && lap_hold_q));
    assign presc_en_c  = (state_q == RUN) && !sw.clear && !sw.stop;
    assign presc_clr_c = sw.clear || load_ok_c;

    assign load_time_c.hour = (sw.load_hour > HOUR_LAST) ? HOUR_LAST : sw.load_hour;
    assign load_time_c.min  = (sw.load_min  > MIN_LAST)  ? MIN_LAST  : sw.load_min;
    assign load_time_c.sec  = (sw.load_sec  > SEC_LAST)  ? SEC_LAST  : sw.load_sec;

    sw_tick_prescaler #(
        .TICK_DIV (TICK_DIV),
        .DIV_W    (DIV_W)
    ) u_presc (
        .clk    (clk),
        .reset  (reset),
        .enable (presc_en_c),
        .clear  (presc_clr_c),
        .tick   (tick_c)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lap_d      = lap_q;
        mode_d     = mode_q;
        lap_hold_d = lap_hold_q;
        done_d     = 1'b0;
        rollover_d = 1'b0;

        if (sw.clear) begin
            cnt_d      = '0;
            lap_hold_d = 1'b0;
            state_d    = IDLE;
        end else if (load_ok_c) begin
            cnt_d   = load_time_c;
            state_d = PAUSE;
        end else if (sw.stop && (state_q == RUN)) begin
            state_d = PAUSE;
        end else begin
            if (start_ok_c) begin
                state_d = RUN;
                mode_d  = sw.mode_down;
            end else if (lap_ok_c) begin
                // Capture uses the pre-tick count.
                lap_hold_d = !lap_hold_q;
                if (!lap_hold_q) begin
                    lap_d = cnt_q;
                end
            end
            if (tick_c) begin
                if (mode_q) begin
                    cnt_d = time_dec(cnt_q);
                    if (cnt_d == '0) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end else begin
                    cnt_d = time_inc(cnt_q);
                    rollover_d = (cnt_d == '0);
                end
            end
        end

        disp_d    = lap_hold_d ? lap_d : cnt_d;
        running_d = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            lap_q      <= '0;
            disp_q     <= '0;
            mode_q     <= 1'b0;
            lap_hold_q <= 1'b0;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
            rollover_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lap_q      <= lap_d;
            disp_q     <= disp_d;
            mode_q     <= mode_d;
            lap_hold_q <= lap_hold_d;
            running_q  <= running_d;
            done_q     <= done_d;
            rollover_q <= rollover_d;
        end
    end

    assign sw.hour     = disp_q.hour;
    assign sw.min      = disp_q.min;
    assign sw.sec      = disp_q.sec;
    assign sw.running  = running_q;
    assign sw.lap_hold = lap_hold_q;
    assign sw.done     = done_q;
    assign sw.rollover = rollover_q;

endmodule

// File: doc/stop_watch_lap.md
Name: stop_watch_lap

Overview:
Parametrised next-generation stopwatch core. It counts hours/minutes/seconds up or down from a configurable tick prescaler. It adds pause/resume, preset load, lap-hold display freeze, countdown-expiry and rollover flags. The block sits between the debounced button/command logic and the display encoder.

Parameters:
TICK_DIV, 1, clk cycles per one-second tick (1 = count every clk, for simulation); must be >= 1
HOUR_MOD, 12, hour modulus; hour counts 0..HOUR_MOD-1; legal range 2..16
DIV_W, 1, prescaler counter width; must satisfy 2**DIV_W >= TICK_DIV

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
start  in  1  start/resume command, level sampled each clk
stop  in  1  pause command
clear  in  1  zero all counters, go IDLE
lap  in  1  toggle lap-hold display freeze
load  in  1  load preset from load_* ports
mode_down  in  1  0 = count up, 1 = count down; sampled only outside RUN
load_hour  in  4  preset hour
load_min  in  6  preset minute
load_sec  in  6  preset second
hour  out  4  displayed hour
min  out  6  displayed minute
sec  out  6  displayed second
running  out  1  high while state is RUN
lap_hold  out  1  display frozen at lap capture
done  out  1  one-cycle pulse on countdown reaching 0:00:00
rollover  out  1  one-cycle pulse on count-up wrap from max to 0:00:00

Behaviour:
- Reset (reset=0, async): state IDLE; counters, prescaler, lap registers and mode all 0; every output 0.
- FSM states: IDLE, RUN, PAUSE, DONE. All outputs are registered.
- Command priority per cycle: clear > load > stop > start > lap.
- clear (any state): counters and prescaler go to 0; lap_hold goes to 0; next state IDLE.
- load (IDLE/PAUSE/DONE only; ignored in RUN):
  - Counters take the load values.
  - Out-of-range values clamp: sec/min to 59, hour to HOUR_MOD-1.
  - Prescaler goes to 0; next state PAUSE.
- start:
  - IDLE/PAUSE go to RUN; mode register latches mode_down on this transition.
  - Ignored in DONE.
  - Ignored when mode_down=1 and the time is 0:00:00; state does not change.
- stop: RUN goes to PAUSE. Prescaler value is retained, so a resume continues the partial second.
- Prescaler:
  - Counts only in RUN. A tick fires in the cycle where prescaler==TICK_DIV-1; the prescaler then wraps to 0.
  - Latency: start asserted at edge N gives running=1 after edge N. The first counter change occurs TICK_DIV cycles later.
- Count up on tick:
  - sec 59 goes to 0 with carry to min; min 59 with carry goes to 0 with carry to hour; hour HOUR_MOD-1 with carry goes to 0.
  - The full wrap to 0:00:00 pulses rollover for 1 cycle and keeps running.
- Count down on tick:
  - Borrow chain mirrors count up (sec 0 goes to 59 with borrow, etc.).
  - The tick that produces 0:00:00 pulses done for 1 cycle and moves to DONE; running goes to 0.
- Lap:
  - In RUN, lap with lap_hold=0 captures the current counters into lap registers and sets lap_hold=1. Outputs show the lap registers; internal counting continues.
  - lap with lap_hold=1 (RUN or PAUSE) clears lap_hold; outputs track the live counters again.
  - lap in IDLE/DONE is ignored.
- Simultaneous tick and lap: the captured value is the pre-tick value.
- Simultaneous tick and stop: stop wins; no increment that cycle.
- Commands are level-sensitive. A held start/stop repeats harmlessly; a held lap toggles every cycle, so the upstream logic supplies single-cycle pulses.
- Reset mid-RUN: immediate async return to reset values; no done or rollover pulse is generated.

Decomposition:
- Shared package sw_pkg holds:
  - State enum (IDLE, RUN, PAUSE, DONE).
  - Constants SEC_MAX=59 and MIN_MAX=59.
  - Field widths SEC_W=6, MIN_W=6 and HOUR_W=4.
- One natural sub-module: sw_tick_prescaler. Inputs clk, reset, enable, clear; output tick; parameters TICK_DIV and DIV_W.
- The counter chain, FSM and lap registers stay in stop_watch_lap.

Test Plan:
- Reset then start with TICK_DIV=1, HOUR_MOD=12 -> after 3600 cycles: hour=1, min=0, sec=0; running=1.
- Load 11:59:58, start (up) -> after 2 ticks outputs 0:00:00; rollover pulses exactly 1 cycle; running stays 1.
- Load 0:00:03, mode_down=1, start -> 3 ticks later 0:00:00; done pulse 1 cycle; state DONE; a later start is ignored and sec stays 0.
- Run to 0:00:10, pulse lap -> outputs hold 0:00:10 for 20 cycles while the internal count reaches 0:00:30; lap again -> outputs show live 0:00:30.
- TICK_DIV=4: start, stop after 6 cycles (sec=1, prescaler=2), wait 10, start -> sec becomes 2 exactly 2 cycles after resume.
- clear and stop in the same cycle during RUN -> 0:00:00, IDLE; reset pulled low mid-run -> all outputs 0 immediately, with no clk edge needed.
